// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: RV32I decode stage between fetch and execute.
// A word accepted from fetch is decoded combinationally and written into a
// 3-deep in-order store: entry 0 is the output register seen by execute, and
// entries 1..2 are the skid entries that absorb words while execute stalls.
// in_ready comes straight from a flop.
// Optional feature macro: RISCV_DECODE_ILLEGAL_TRAP_EN. When it is defined,
// an unsupported opcode is flagged on out_illegal and intake stops until flush.

package riscv;
  typedef logic [31:0] ir_t;
  typedef logic [8:0]  pc_t;
  typedef logic [4:0]  addr_t;
  typedef logic [31:0] imm_t;
  typedef logic [3:0]  funct_t;
  typedef enum logic [1:0] {
    PC_PLUS4_TGT = 2'd0,
    JAL_BXX_TGT  = 2'd1,
    JALR_TGT     = 2'd2
  } tgt_t;

  // ALU function codes are {funct7[5], funct3}
  localparam funct_t F_ADD  = 4'b0000;
  localparam funct_t F_SUB  = 4'b1000;
  localparam funct_t F_SLT  = 4'b0010;
  localparam funct_t F_SLTU = 4'b0011;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0, x0, 0
  localparam ir_t NOP = 32'h0000_0013;

  typedef struct packed {
    pc_t        pc;
    addr_t      rd;
    addr_t      rs1;
    addr_t      rs2;
    imm_t       imm;
    funct_t     funct;
    tgt_t       tgt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       illegal;
  } dec_t;
endpackage

module riscv_decode_stage
  import riscv::*;
#(
  parameter int SKID_DEPTH   = 2,
  parameter bit NOP_ON_FLUSH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  ir_t        in_ir,
  input  pc_t        in_pc,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output pc_t        out_pc,
  output addr_t      out_rd,
  output addr_t      out_rs1,
  output addr_t      out_rs2,
  output imm_t       out_imm,
  output funct_t     out_funct,
  output tgt_t       out_tgt,
  output logic [6:0] out_opcode,
  output logic [2:0] out_funct3,
  output logic       out_illegal
);

  if (SKID_DEPTH != 2) begin : g_bad_skid_depth
    $error("riscv_decode_stage: SKID_DEPTH must be 2");
  end

  // Decoded form of the canonical NOP, used for reset, flush and unsupported opcodes
  function automatic dec_t nop_bundle(input pc_t pc);
    dec_t d;
    d.pc      = pc;
    d.rd      = '0;
    d.rs1     = '0;
    d.rs2     = '0;
    d.imm     = '0;
    d.funct   = F_ADD;
    d.tgt     = PC_PLUS4_TGT;
    d.opcode  = NOP[6:0];
    d.funct3  = NOP[14:12];
    d.illegal = 1'b0;
    return d;
  endfunction

  function automatic dec_t decode(input ir_t ir, input pc_t pc);
    dec_t d;
    d.pc      = pc;
    d.rd      = ir[11:7];
    d.rs1     = ir[19:15];
    d.rs2     = ir[24:20];
    d.imm     = '0;
    d.funct   = F_ADD;
    d.tgt     = PC_PLUS4_TGT;
    d.opcode  = ir[6:0];
    d.funct3  = ir[14:12];
    d.illegal = 1'b0;
    case (ir[6:0])
      OPC_LUI, OPC_AUIPC: begin
        d.imm = {ir[31:12], 12'b0};
        d.rs1 = '0;
        d.rs2 = '0;
      end
      OPC_JAL: begin
        d.imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
        d.rs1 = '0;
        d.rs2 = '0;
        d.tgt = JAL_BXX_TGT;
      end
      OPC_JALR: begin
        d.imm = {{21{ir[31]}}, ir[30:20]};
        d.rs2 = '0;
        d.tgt = JALR_TGT;
      end
      OPC_BRANCH: begin
        d.imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
        d.rd  = '0;
        d.tgt = JAL_BXX_TGT;
        // Compare kind comes from funct3[2:1]: eq/ne, signed lt/ge, unsigned lt/ge
        case (ir[14:13])
          2'b10:   d.funct = F_SLT;
          2'b11:   d.funct = F_SLTU;
          default: d.funct = F_SUB;
        endcase
      end
      OPC_LOAD: begin
        d.imm = {{21{ir[31]}}, ir[30:20]};
        d.rs2 = '0;
      end
      OPC_STORE: begin
        d.imm = {{21{ir[31]}}, ir[30:25], ir[11:7]};
        d.rd  = '0;
      end
      OPC_OP_IMM: begin
        d.imm   = {{21{ir[31]}}, ir[30:20]};
        d.rs2   = '0;
        // Only SRLI/SRAI carry a meaningful funct7[5]; other immediates reuse that bit
        d.funct = {(ir[14:12] == 3'b101) & ir[30], ir[14:12]};
      end
      OPC_OP: begin
        d.funct = {ir[30], ir[14:12]};
      end
      default: begin
        d = nop_bundle(pc);
`ifdef RISCV_DECODE_ILLEGAL_TRAP_EN
        d.illegal = 1'b1;
`endif
      end
    endcase
    return d;
  endfunction

  dec_t       ent_q [3];
  dec_t       ent_d [3];
  dec_t       dec_in;
  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       lock_q, lock_d;
  logic       push, pop;

  assign dec_in = decode(in_ir, in_pc);
  assign push   = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  // Next state of the in-order store: flush wins, then drain, then append
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    ent_d  = ent_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;
    if (flush) begin
      cnt_d  = '0;
      lock_d = 1'b0;
    end else begin
      if (pop) begin
        ent_d[0] = ent_q[1];
        ent_d[1] = ent_q[2];
        cnt_d    = cnt_q - 2'd1;
      end
      if (push) begin
        for (int i = 0; i < 3; i++) begin
          if (cnt_d == 2'(i)) ent_d[i] = dec_in;
        end
        cnt_d = cnt_d + 2'd1;
`ifdef RISCV_DECODE_ILLEGAL_TRAP_EN
        if (dec_in.illegal) lock_d = 1'b1;
`endif
      end
    end
    // An empty output register shows either the NOP decode or its last contents
    if (cnt_d == 2'd0) ent_d[0] = NOP_ON_FLUSH ? nop_bundle('0) : ent_q[0];
    // Ready while fewer than two skid entries will be occupied
    in_ready_d = ~lock_d & (cnt_d != 2'd3);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      lock_q     <= 1'b0;
      // NOTE: the entries are reset too so out_* show the NOP decode straight out of reset.
      for (int i = 0; i < 3; i++) ent_q[i] <= nop_bundle('0);
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values regardless of statement order.
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      lock_q     <= lock_d;
      for (int i = 0; i < 3; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (cnt_q != 2'd0);
  assign out_pc      = ent_q[0].pc;
  assign out_rd      = ent_q[0].rd;
  assign out_rs1     = ent_q[0].rs1;
  assign out_rs2     = ent_q[0].rs2;
  assign out_imm     = ent_q[0].imm;
  assign out_funct   = ent_q[0].funct;
  assign out_tgt     = ent_q[0].tgt;
  assign out_opcode  = ent_q[0].opcode;
  assign out_funct3  = ent_q[0].funct3;
  assign out_illegal = ent_q[0].illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: scoreboard bench for riscv_decode_stage.
// Words are built from chosen fields (rd, rs1, rs2, immediate value, funct3),
// and the expected decode is taken from those fields, not from the encoded bits.
module tb_riscv_decode_stage;
  import riscv::*;

`ifdef RISCV_DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6F, T_JALR = 7'h67;
  localparam logic [6:0] T_BR  = 7'h63, T_LD = 7'h03, T_ST = 7'h23, T_OPI = 7'h13, T_OP = 7'h33;
  localparam logic [3:0] E_ADD = 4'h0, E_SUB = 4'h8, E_SLT = 4'h2, E_SLTU = 4'h3, E_SRA = 4'hD;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  ir_t        in_ir;
  pc_t        in_pc, out_pc;
  addr_t      out_rd, out_rs1, out_rs2;
  imm_t       out_imm;
  funct_t     out_funct;
  tgt_t       out_tgt;
  logic [6:0] out_opcode;
  logic [2:0] out_funct3;

  riscv_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_funct(out_funct), .out_tgt(out_tgt),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [8:0]  pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  funct;
    tgt_t        tgt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        illegal;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: field-level instruction builders ----------------
  function automatic exp_t blank(input logic [8:0] pc, input logic [6:0] op);
    exp_t e;
    e.ir = '0; e.pc = pc; e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.imm = '0;
    e.funct = E_ADD; e.tgt = PC_PLUS4_TGT; e.opcode = op; e.funct3 = '0; e.illegal = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_i(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input int imm, input logic [8:0] pc);
    exp_t e = blank(pc, op);
    logic [31:0] v = imm;
    e.ir = {v[11:0], rs1, f3, rd, op};
    e.rd = rd; e.rs1 = rs1; e.imm = v; e.funct3 = f3;
    if (op == T_OPI) e.funct = {(f3 == 3'd5) && v[10], f3};
    if (op == T_JALR) e.tgt = JALR_TGT;
    return e;
  endfunction

  function automatic exp_t mk_s(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                input int imm, input logic [8:0] pc);
    exp_t e = blank(pc, T_ST);
    logic [31:0] v = imm;
    e.ir = {v[11:5], rs2, rs1, f3, v[4:0], T_ST};
    e.rs1 = rs1; e.rs2 = rs2; e.imm = v; e.funct3 = f3;
    return e;
  endfunction

  function automatic exp_t mk_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                input int off, input logic [8:0] pc);
    exp_t e = blank(pc, T_BR);
    logic [31:0] v = off;
    e.ir = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], T_BR};
    e.rs1 = rs1; e.rs2 = rs2; e.imm = v; e.funct3 = f3; e.tgt = JAL_BXX_TGT;
    case (f3)
      3'd4, 3'd5: e.funct = E_SLT;
      3'd6, 3'd7: e.funct = E_SLTU;
      default:    e.funct = E_SUB;
    endcase
    return e;
  endfunction

  function automatic exp_t mk_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] up,
                                input logic [8:0] pc);
    exp_t e = blank(pc, op);
    e.ir = {up, rd, op};
    e.rd = rd; e.imm = {up, 12'h000}; e.funct3 = up[2:0];
    return e;
  endfunction

  function automatic exp_t mk_j(input logic [4:0] rd, input int off, input logic [8:0] pc);
    exp_t e = blank(pc, T_JAL);
    logic [31:0] v = off;
    e.ir = {v[20], v[10:1], v[11], v[19:12], rd, T_JAL};
    e.rd = rd; e.imm = v; e.funct3 = v[14:12]; e.tgt = JAL_BXX_TGT;
    return e;
  endfunction

  function automatic exp_t mk_r(input logic f7b, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [8:0] pc);
    exp_t e = blank(pc, T_OP);
    e.ir = {1'b0, f7b, 5'b00000, rs2, rs1, f3, rd, T_OP};
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.funct3 = f3;
    e.funct = f7b ? (4'd8 + {1'b0, f3}) : {1'b0, f3};
    return e;
  endfunction

  // Unsupported opcode: decodes as the NOP, pc kept, flagged only when trapping
  function automatic exp_t mk_ill(input logic [6:0] op, input logic [24:0] rest, input logic [8:0] pc);
    exp_t e = blank(pc, T_OPI);
    e.ir = {rest, op};
    e.illegal = TRAP;
    return e;
  endfunction

  function automatic exp_t rand_word(input bit allow_ill);
    logic [8:0] pc  = 9'($urandom_range(0, 511));
    logic [4:0] rd  = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
    logic [2:0] f3  = 3'($urandom);
    int         i12 = int'($urandom_range(0, 4095)) - 2048;
    logic [6:0] op;
    case ($urandom_range(0, allow_ill ? 9 : 8))
      0: return mk_u(T_LUI, rd, 20'($urandom), pc);
      1: return mk_u(T_AUIPC, rd, 20'($urandom), pc);
      2: return mk_j(rd, (int'($urandom_range(0, 1048575)) - 524288) * 2, pc);
      3: return mk_i(T_JALR, 3'd0, rd, rs1, i12, pc);
      4: begin
        case ($urandom_range(0, 5))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4; 3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
        endcase
        return mk_b(f3, rs1, rs2, (int'($urandom_range(0, 4095)) - 2048) * 2, pc);
      end
      5: return mk_i(T_LD, f3, rd, rs1, i12, pc);
      6: return mk_s(f3, rs1, rs2, i12, pc);
      7: begin
        if (f3 == 3'd1) i12 = int'($urandom_range(0, 31));
        if (f3 == 3'd5) i12 = int'($urandom_range(0, 1)) * 1024 + int'($urandom_range(0, 31));
        return mk_i(T_OPI, f3, rd, rs1, i12, pc);
      end
      8: return mk_r(1'($urandom), f3, rd, rs1, rs2, pc);
      default: begin
        do op = 7'($urandom);
        while (op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_OPI, T_OP});
        return mk_ill(op, 25'($urandom), pc);
      end
    endcase
  endfunction

  // ---------------- monitor: pops the scoreboard on every drain ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !flush && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("out_valid_unexpected", out_valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_rd", out_rd, e.rd);
          check("out_rs1", out_rs1, e.rs1);
          check("out_rs2", out_rs2, e.rs2);
          check("out_imm", out_imm, e.imm);
          check("out_funct", out_funct, e.funct);
          check("out_tgt", out_tgt, e.tgt);
          check("out_opcode", out_opcode, e.opcode);
          check("out_funct3", out_funct3, e.funct3);
          check("out_illegal", out_illegal, e.illegal);
        end
      end
    end
  end

  // ---------------- driver helpers (all return just after a rising edge) ----------------
  task automatic to_drive();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input exp_t e);
    bit acc = 1'b0;
    in_valid = 1'b1; in_ir = e.ir; in_pc = e.pc;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        acc = 1'b1;
        break;
      end
      to_drive();
    end
    if (!acc) check("send_timeout_in_ready", in_ready, 1'b1);
    to_drive();
    in_valid = 1'b0;
  endtask

  task automatic do_flush(input bit with_word);
    exp_t e;
    flush = 1'b1;
    if (with_word) begin
      e = rand_word(1'b0);
      in_valid = 1'b1; in_ir = e.ir; in_pc = e.pc;
    end
    @(negedge clk);
    sb_q.delete();
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_nop_imm", out_imm, 32'h0);
    check("flush_nop_funct", out_funct, E_ADD);
    check("flush_nop_rd", out_rd, 5'd0);
    to_drive();
  endtask

  // Called at a falling edge with reset high
  task automatic release_reset();
    reset = 1'b0;
    #1;
    check("in_ready_before_first_edge", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin : main
    exp_t e;
    reset = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_imm", out_imm, 32'h0);
    check("rst_out_funct", out_funct, E_ADD);
    check("rst_out_pc", out_pc, 9'h0);
    check("rst_out_tgt", out_tgt, PC_PLUS4_TGT);
    check("rst_out_illegal", out_illegal, 1'b0);
    release_reset();

    // ADDI x1, x0, -5 at pc 0x004: one-cycle latency
    out_ready = 1'b1;
    send(mk_i(T_OPI, 3'd0, 5'd1, 5'd0, -5, 9'h004));
    @(negedge clk);
    check("addi_latency_valid", out_valid, 1'b1);
    check("addi_imm", out_imm, 32'hFFFF_FFFB);
    check("addi_pc", out_pc, 9'h004);
    to_drive();

    // SUB x3, x1, x2 ; SRAI shamt 4 ; BLTU offset -8
    send(mk_r(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 9'h008));
    @(negedge clk);
    check("sub_funct", out_funct, E_SUB);
    to_drive();
    send(mk_i(T_OPI, 3'd5, 5'd4, 5'd1, 1024 + 4, 9'h00C));
    @(negedge clk);
    check("srai_funct", out_funct, E_SRA);
    to_drive();
    send(mk_b(3'd6, 5'd1, 5'd2, -8, 9'h010));
    @(negedge clk);
    check("bltu_imm", out_imm, 32'hFFFF_FFF8);
    check("bltu_funct", out_funct, E_SLTU);
    check("bltu_tgt", out_tgt, JAL_BXX_TGT);
    check("bltu_rd", out_rd, 5'd0);
    to_drive();

    // Backpressure: three words fit, a fourth is refused
    out_ready = 1'b0;
    repeat (3) send(rand_word(1'b0));
    e = rand_word(1'b0);
    in_valid = 1'b1; in_ir = e.ir; in_pc = e.pc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready_full", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      to_drive();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_drain_no_gap", out_valid, (k < 3) ? 1'b1 : 1'b0);
      to_drive();
    end

    // Flush with skid full and a word offered, then with in_ready high and a word offered
    out_ready = 1'b0;
    repeat (3) send(rand_word(1'b0));
    do_flush(1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_word_dropped", out_valid, 1'b0);
      to_drive();
    end
    out_ready = 1'b0;
    repeat (2) send(rand_word(1'b0));
    do_flush(1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_accept_dropped", out_valid, 1'b0);
      to_drive();
    end

    // Unsupported opcode 7'b0000000
    send(mk_ill(7'b0000000, 25'($urandom), 9'h1A4));
    @(negedge clk);
    check("ill_out_valid", out_valid, 1'b1);
    check("ill_flag", out_illegal, TRAP);
    check("ill_in_ready", in_ready, !TRAP);
    to_drive();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ill_in_ready_hold", in_ready, !TRAP);
      to_drive();
    end
    do_flush(1'b0);

    // Randomized traffic with random backpressure, gaps and occasional flushes
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) do_flush(1'b1);
      repeat ($urandom_range(0, 2)) to_drive();
      send(rand_word(!TRAP));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 200 && sb_q.size() != 0; w++) to_drive();
    check("scoreboard_drained", sb_q.size(), 0);

    // Reset asserted mid-stream with two words buffered
    out_ready = 1'b0;
    repeat (2) send(rand_word(1'b0));
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("rst_mid_out_imm", out_imm, 32'h0);
    check("rst_mid_out_funct", out_funct, E_ADD);
    release_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_words_gone", out_valid, 1'b0);
      to_drive();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- Pipelined instruction decoder that sits between fetch and execute.
- Accepts a raw `riscv::ir_t` word and its `pc_t` from fetch over a valid/ready handshake.
- Extracts register addresses, builds the sign-extended immediate, and derives the ALU function and PC target class.
- Presents registered results to execute over a second valid/ready handshake. A 2-entry skid buffer lets `in_ready` be driven straight from a register.

Parameters:
- SKID_DEPTH, 2, number of skid entries. The only legal value is 2; the block errors at elaboration if set otherwise.
- NOP_ON_FLUSH, 1, when 1 the output fields hold the decode of `riscv::NOP` while `out_valid`=0; when 0 they hold their last values.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch word valid
- in_ready  out  1  decoder can accept a word
- in_ir  in  32  instruction, `riscv::ir_t`
- in_pc  in  9  instruction address, `riscv::pc_t`
- flush  in  1  discard everything in flight (branch taken / trap)
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  9  pc of the decoded instruction
- out_rd / out_rs1 / out_rs2  out  5 each  register addresses (`addr_t`)
- out_imm  out  32  sign-extended immediate (`imm_t`)
- out_funct  out  4  ALU function (`funct_t`)
- out_tgt  out  2  PC target class (`tgt_t`)
- out_opcode  out  7  opcode passthrough
- out_funct3  out  3  funct3 passthrough
- out_illegal  out  1  unsupported opcode (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-high.
  - Reset values: `out_valid`=0, `in_ready`=0, skid buffer empty.
  - All output fields take the decode of `riscv::NOP`: `funct` ADD, `imm` 0, rd/rs1/rs2 0, `tgt` PC_PLUS4_TGT, `out_pc`=0, `out_illegal`=0.
- `in_ready` rises to 1 on the first clk edge after reset deasserts.
- Latency: a word accepted (`in_valid & in_ready`) at edge N appears with `out_valid`=1 after edge N. That is 1 cycle, when the output register is empty or being drained.
- Handshakes follow standard valid/ready.
  - Input and output payloads must hold while valid is high and ready is low.
  - `out_*` fields are stable while `out_valid & !out_ready`.
- Skid buffer: when `out_valid & !out_ready`, accepted words are decoded into skid entries.
  - `in_ready` = (skid occupancy < 2), registered.
  - Order is strictly FIFO: output register first, then skid[0], then skid[1].
  - Full: 2 skid entries plus 1 output entry means `in_ready`=0. No word may be lost or duplicated.
- Simultaneous accept and drain in the same cycle: occupancy is unchanged, and the next word advances into the output register.
- Immediate construction:
  - I-type: sign-extend imm[11:0].
  - S-type: sign-extend imm[11:0].
  - SB-type: sign-extend {imm[12:1],0}.
  - U-type: {imm[31:12],12'b0}.
  - UJ-type: sign-extend {imm[20:1],0}.
  - OP (R-type): 0.
- ALU function:
  - OP: {funct7[5], funct3}.
  - OP_IMM: funct3, with bit 3 = funct7[5] only when funct3 is SRLI/SRAI; otherwise bit 3 = 0.
  - LOAD, STORE, JAL, JALR, AUIPC, LUI: ADD.
  - BRANCH: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
- Target class: JALR → JALR_TGT; JAL and BRANCH → JAL_BXX_TGT; all others → PC_PLUS4_TGT.
- Register fields:
  - rd is forced to 0 for STORE and BRANCH.
  - rs2 is forced to 0 for I, U and UJ formats.
  - rs1 is forced to 0 for LUI, AUIPC and JAL.
- Flush:
  - Synchronous. At the edge where flush=1, `out_valid`←0 and the skid is emptied.
  - Any word presented that same cycle is dropped, even if `in_valid & in_ready`.
  - `in_ready` is 1 the next cycle.
  - Flush takes priority over accept and drain.
- Unsupported opcodes (not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP): handled per the Optional Feature.

Optional Feature:
- Macro RISCV_DECODE_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode decodes with `out_illegal`=1, fields as NOP, and the original `out_pc` preserved. The block then deasserts `in_ready` until flush is seen, so no younger word enters behind the trap.
- Undefined: an unsupported opcode decodes silently as `riscv::NOP` with `out_illegal` tied to 0, and the pipeline continues.

Test Plan:
- Reset check: assert reset mid-stream with 2 words buffered → `out_valid`=0 and `in_ready`=0 immediately; `in_ready`=1 one edge after release; `out_imm`=0, `out_funct`=ADD.
- OP_IMM ADDI rd=1 rs1=0 imm=-5, pc=9'h004 → 1 cycle later `out_imm`=32'hFFFF_FFFB, `out_funct`=ADD, `out_rd`=1, `out_rs2`=0, `out_tgt`=PC_PLUS4_TGT, `out_pc`=9'h004.
- OP SUB rd=3 rs1=1 rs2=2, then SRAI shamt=4 → `out_funct`=SUB then SRA; BRANCH BLTU offset -8 → `out_imm`=32'hFFFF_FFF8, `funct` SLTU, `tgt` JAL_BXX_TGT, `rd`=0.
- Backpressure: hold `out_ready`=0 and stream 4 words → exactly 3 accepted, `in_ready`=0; release `out_ready` → the 3 words appear in order with no gaps; no duplicates.
- Flush with `in_valid`=1 and skid full → next cycle `out_valid`=0 and `in_ready`=1; the word presented on the flush cycle never appears.
- Opcode 7'b0000000: with macro → `out_illegal`=1 and `in_ready`=0 until flush; without macro → NOP decode with `out_illegal`=0.
